clmul_reduce_acc: RTL and testbench

CLMUL_REDUCE_ACC -- requirements
Module: clmul_reduce_acc

---
 rtl/clmul_reduce_acc_if.sv | 32 +++
 rtl/clmul_reduce_acc.sv | 72 +++++++
 tb/tb_clmul_reduce_acc.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/clmul_reduce_acc_if.sv
// clmul_reduce_acc_if: handshake bus between the product source, the GF(16) accumulator and the result sink
// Optional feature macro: CLMUL_ACC_CNT_EN adds out_cnt (beats in the held frame)
// in_valid/in_ready/in_prod/in_last : upstream beat channel carrying 8-bit carry-less products
// out_valid/out_ready/out_sum        : downstream frame-result channel carrying the 4-bit GF(16) sum
// err                                : sticky flag for accepted beats with in_prod[7] set
interface clmul_reduce_acc_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_prod;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       err;
`ifdef CLMUL_ACC_CNT_EN
  logic [4:0] out_cnt;
`endif
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, err
`ifdef CLMUL_ACC_CNT_EN
    , input out_cnt
`endif
  );
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, err
`ifdef CLMUL_ACC_CNT_EN
    , output out_cnt
`endif
  );
endinterface

// File: rtl/clmul_reduce_acc.sv
// clmul_reduce_acc: reduces carry-less products mod POLY and XOR-accumulates them per frame into a GF(16) sum
// Optional feature macro: CLMUL_ACC_CNT_EN adds a saturating per-frame beat counter on out_cnt
// clk    : rising-edge clock
// rst    : synchronous active-high reset
// bus_io : slave side of clmul_reduce_acc_if (beat input, result output, err, optional out_cnt)
module clmul_reduce_acc #(
  parameter logic [4:0] POLY = 5'b10011
) (
  input logic               clk,
  input logic               rst,
  clmul_reduce_acc_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;
  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d, sum_q, sum_d, red;
  logic       err_q, err_d, rdy, fire, last_fire;
  // Long division over GF(2): clear bits 6..4 from the top using shifted copies of POLY
  function automatic logic [3:0] reduce(input logic [6:0] p);
    logic [6:0] r;
    r = p;
    for (int i = 6; i >= 4; i--)
      if (r[i]) r ^= 7'(POLY) << (i - 4);
    return r[3:0];
  endfunction
  assign rdy       = state_q != HOLD || bus_io.out_ready;
  assign fire      = bus_io.in_valid && rdy;
  assign last_fire = fire && bus_io.in_last;
  // acc is already zero while HOLD, so a beat accepted on the consuming edge starts a fresh frame
  always_comb begin
    red     = reduce(bus_io.in_prod[6:0]);
    acc_d   = fire ? (bus_io.in_last ? 4'd0 : acc_q ^ red) : acc_q;
    sum_d   = last_fire ? acc_q ^ red : sum_q;
    err_d   = err_q | (fire & bus_io.in_prod[7]);
    state_d = fire ? (bus_io.in_last ? HOLD : ACC)
                   : (state_q == HOLD && bus_io.out_ready ? IDLE : state_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end
  assign bus_io.in_ready  = rdy;
  assign bus_io.out_valid = state_q == HOLD;
  assign bus_io.out_sum   = sum_q;
  assign bus_io.err       = err_q;
`ifdef CLMUL_ACC_CNT_EN
  logic [4:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_inc;
  always_comb begin
    cnt_inc = &cnt_q ? cnt_q : cnt_q + 5'd1;
    cnt_d   = fire ? (bus_io.in_last ? 5'd0 : cnt_inc) : cnt_q;
    ocnt_d  = last_fire ? cnt_inc : ocnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      ocnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ocnt_q <= ocnt_d;
    end
  end
  assign bus_io.out_cnt = ocnt_q;
`endif
endmodule

// File: tb/tb_clmul_reduce_acc.sv
// tb_clmul_reduce_acc: directed self-checking bench with a scoreboard of expected frame results
module tb_clmul_reduce_acc;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [3:0] sq[$];
  logic [4:0] cq[$];
  logic [3:0] m_acc, held;
  logic [4:0] m_cnt;
  logic       m_err;
  clmul_reduce_acc_if bus();
  clmul_reduce_acc dut (.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  // Reference remainder from the powers x^4=0x3, x^5=0x6, x^6=0xC modulo x^4+x+1
  function automatic logic [3:0] mred(input logic [7:0] p);
    return p[3:0] ^ (p[4] ? 4'h3 : 4'h0) ^ (p[5] ? 4'h6 : 4'h0) ^ (p[6] ? 4'hC : 4'h0);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] p, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    m_err = m_err | p[7];
    m_cnt = m_cnt == 5'd31 ? m_cnt : m_cnt + 5'd1;
    if (last) begin
      sq.push_back(m_acc ^ mred(p));
      cq.push_back(m_cnt);
      m_acc = 4'h0;
      m_cnt = 5'd0;
    end else m_acc = m_acc ^ mred(p);
  endtask
  task automatic result(input string tag);
    logic [4:0] c;
    held = sq.pop_front();
    c = cq.pop_front();
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_sum"}, bus.out_sum, held);
`ifdef CLMUL_ACC_CNT_EN
    chk({tag, "_cnt"}, bus.out_cnt, c);
`endif
  endtask
  task automatic model_reset();
    m_acc = 4'h0;
    m_cnt = 5'd0;
    m_err = 1'b0;
    sq.delete();
    cq.delete();
  endtask
  initial begin
    model_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_prod = 8'h00;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.out_sum, 4'h0);
    chk("rst_err", bus.err, 1'b0);
`ifdef CLMUL_ACC_CNT_EN
    chk("rst_cnt", bus.out_cnt, 5'd0);
`endif
    rst = 1'b0;
    step();
    chk("idle_ready", bus.in_ready, 1'b1);
    send(8'h40, 1'b1);
    result("single");
    step();
    chk("single_drop", bus.out_valid, 1'b0);
    send(8'h12, 1'b0);
    send(8'h07, 1'b0);
    send(8'h30, 1'b1);
    result("three");
    step();
    chk("three_pulse", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    send(8'h12, 1'b0);
    send(8'h07, 1'b0);
    send(8'h30, 1'b1);
    result("hold");
    bus.in_valid = 1'b1;
    bus.in_prod = 8'h12;
    bus.in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_ready", bus.in_ready, 1'b0);
      step();
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_sum", bus.out_sum, held);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    send(8'h0F, 1'b1);
    result("relast");
    send(8'h85, 1'b0);
    send(8'h00, 1'b1);
    result("err_frame");
    chk("err_set", bus.err, m_err);
    step();
    chk("err_sticky", bus.err, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 33; i++) send({1'b0, 7'($urandom_range(0, 127))}, 1'b0);
      send({1'b0, 7'($urandom_range(0, 127))}, 1'b1);
      result("long");
    end
    step();
    chk("long_drop", bus.out_valid, 1'b0);
    send(8'h12, 1'b0);
    send(8'h07, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_valid", bus.out_valid, 1'b0);
    rst = 1'b0;
    model_reset();
    step();
    chk("postrst_valid", bus.out_valid, 1'b0);
    chk("postrst_err", bus.err, 1'b0);
    send(8'h05, 1'b1);
    result("postrst");
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
